rvv_backend_vrf_mp: RTL

//  Parametrised multi-port vector register file for the RVV backend: NUM_REG x VLEN bits,
//  NUM_RD registered read ports, NUM_WR byte-strobed write ports with deterministic

---
 rtl/rvv_backend_vrf_mp_if.sv | 40 ++++
 rtl/rvv_backend_vrf_mp.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rvv_backend_vrf_mp_if.sv
// Bundle of the vector register file's request and response signals.
//   master : dispatch/retire side. Drives the read, write and clear requests.
//   slave  : register file side. Returns the read data, v0 and the clear status.
// Signals (widths follow the parameters):
//   rd_valid/rd_index              read request per read port
//   rd_data/rd_data_valid          registered read response per read port
//   v0_data                        live contents of v0
//   wr_valid/wr_index/wr_data/wr_strobe   byte-strobed write per write port
//   clr_req/clr_busy               clear-file request pulse and engine status
interface rvv_backend_vrf_mp_if #(
    parameter int VLEN    = 128,
    parameter int NUM_REG = 32,
    parameter int NUM_RD  = 4,
    parameter int NUM_WR  = 4
);
    localparam int VLENB = VLEN / 8;
    localparam int IDXW  = $clog2(NUM_REG);

    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD*IDXW-1:0]   rd_index;
    logic [NUM_RD*VLEN-1:0]   rd_data;
    logic [NUM_RD-1:0]        rd_data_valid;
    logic [VLEN-1:0]          v0_data;
    logic [NUM_WR-1:0]        wr_valid;
    logic [NUM_WR*IDXW-1:0]   wr_index;
    logic [NUM_WR*VLEN-1:0]   wr_data;
    logic [NUM_WR*VLENB-1:0]  wr_strobe;
    logic                     clr_req;
    logic                     clr_busy;

    modport master (
        output rd_valid, rd_index, wr_valid, wr_index, wr_data, wr_strobe, clr_req,
        input  rd_data, rd_data_valid, v0_data, clr_busy
    );

    modport slave (
        input  rd_valid, rd_index, wr_valid, wr_index, wr_data, wr_strobe, clr_req,
        output rd_data, rd_data_valid, v0_data, clr_busy
    );
endinterface

// File: rtl/rvv_backend_vrf_mp.sv
// Multi-port vector register file for the RVV backend.
// The file holds NUM_REG registers of VLEN bits. It has NUM_RD registered read ports,
// NUM_WR byte-strobed write ports and a clear engine that zeroes the file over several cycles.
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset. It zeroes the file and the read outputs and
//           puts the clear engine in IDLE.
//   bus     rvv_backend_vrf_mp_if.slave, which carries the read, write and clear signals.
// Behaviour:
//   - When several write ports hit the same byte in one cycle, the highest port index wins.
//   - While the clear engine is busy, writes are dropped.
// Optional feature (macro RVV_VRF_BYPASS_EN):
//   defined   : a read forwards the bytes written in the same cycle (read-after-write).
//   undefined : a read returns the contents from before the edge (read-before-write).
//
// Clear FSM:
//   state   | meaning
//   S_IDLE  | normal operation; clr_req starts a clear
//   S_CLEAR | zeroing block r_clr_cnt of CLR_PER_CYCLE registers each cycle; writes dropped
module rvv_backend_vrf_mp #(
    parameter int VLEN          = 128,
    parameter int NUM_REG       = 32,
    parameter int NUM_RD        = 4,
    parameter int NUM_WR        = 4,
    parameter int CLR_PER_CYCLE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rvv_backend_vrf_mp_if.slave  bus
);
    localparam int VLENB   = VLEN / 8;
    localparam int IDXW    = $clog2(NUM_REG);
    localparam int NUM_CLR = NUM_REG / CLR_PER_CYCLE;
    localparam int CNTW    = (NUM_CLR > 1) ? $clog2(NUM_CLR) : 1;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CNTW-1:0]            r_clr_cnt;
    logic [CNTW-1:0]            w_clr_cnt_nxt;
    logic                       w_clr_busy;
    logic                       w_wr_allow;

    logic [VLEN-1:0]            r_regs [NUM_REG];
    logic [NUM_REG-1:0][VLENB-1:0] w_wr_en;
    logic [VLEN-1:0]            w_wr_data [NUM_REG];
    logic [VLEN-1:0]            w_rd_val [NUM_RD];
    logic [NUM_RD*VLEN-1:0]     r_rd_data;
    logic [NUM_RD-1:0]          r_rd_valid;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                // clr_req is ignored here, so a second request cannot restart the sweep.
                if (r_clr_cnt == CNTW'(NUM_CLR - 1)) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_clr_busy = (r_state == S_CLEAR);
        w_wr_allow = (r_state == S_IDLE);
    end

    // ---------------- write merge ----------------
    // The ports are scanned in ascending order, so a higher port overwrites a lower
    // one byte by byte. An index that matches no register (out of range) drops the write.
    always_comb begin
        w_wr_en   = '0;
        w_wr_data = '{default: '0};
        for (int r = 0; r < NUM_REG; r++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_allow && bus.wr_valid[p] &&
                    (int'(bus.wr_index[p*IDXW +: IDXW]) == r)) begin
                    for (int b = 0; b < VLENB; b++) begin
                        if (bus.wr_strobe[p*VLENB + b]) begin
                            w_wr_en[r][b]          = 1'b1;
                            w_wr_data[r][b*8 +: 8] = bus.wr_data[p*VLEN + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REG; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REG; r++) begin
                if (w_clr_busy && ((r / CLR_PER_CYCLE) == int'(r_clr_cnt))) begin
                    r_regs[r] <= '0;
                end else begin
                    for (int b = 0; b < VLENB; b++) begin
                        if (w_wr_en[r][b]) begin
                            r_regs[r][b*8 +: 8] <= w_wr_data[r][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_rd_val = '{default: '0};
        for (int i = 0; i < NUM_RD; i++) begin
            v_idx = int'(bus.rd_index[i*IDXW +: IDXW]);
            if (v_idx < NUM_REG) begin
                w_rd_val[i] = r_regs[v_idx];
`ifdef RVV_VRF_BYPASS_EN
                // w_wr_en is already gated by the clear engine, so a dropped write is never forwarded.
                for (int b = 0; b < VLENB; b++) begin
                    if (w_wr_en[v_idx][b]) begin
                        w_rd_val[i][b*8 +: 8] = w_wr_data[v_idx][b*8 +: 8];
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= bus.rd_valid;
            for (int i = 0; i < NUM_RD; i++) begin
                if (bus.rd_valid[i]) begin
                    r_rd_data[i*VLEN +: VLEN] <= w_rd_val[i];
                end
            end
        end
    end

    assign bus.rd_data       = r_rd_data;
    assign bus.rd_data_valid = r_rd_valid;
    assign bus.v0_data       = r_regs[0];
    assign bus.clr_busy      = w_clr_busy;
endmodule
